// File: rtl/seq_chunk_adder.sv
// -----------------------------------------------------------------------------
// seq_chunk_adder
//   Multi-cycle adder for the multi-cycle ALU. Adds two WIDTH-bit operands
//   CHUNK bits per clock, least-significant slice first, carrying between
//   slices in a register. The combinational carry chain is therefore CHUNK
//   bits long instead of WIDTH.
//
//   Optional feature macro: SEQ_ADDER_SUB_EN
//     defined   : adds the 'sub' port; sub=1 computes in1 + ~in2 + 1
//                 (c_in ignored, c_out=1 means no borrow).
//     undefined : addition only, no 'sub' port.
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-high reset
//   start  in   operation request, sampled only in IDLE
//   in1    in   operand A, captured when start is accepted
//   in2    in   operand B, captured when start is accepted
//   c_in   in   carry into bit 0, captured when start is accepted
//   sub    in   subtract select (only with SEQ_ADDER_SUB_EN)
//   busy   out  high while in RUN or DONE
//   done   out  one-cycle pulse, result valid
//   sum    out  result, held until the next operation completes
//   c_out  out  carry out of bit WIDTH-1
//   ovf    out  two's-complement signed overflow
// -----------------------------------------------------------------------------
module seq_chunk_adder #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             c_in,
`ifdef SEQ_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ovf
);

   localparam int NCHUNK = WIDTH / CHUNK;
   // Slice index needs at least one bit even when NCHUNK == 1.
   localparam int KW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

   if ((WIDTH % CHUNK) != 0 || CHUNK <= 0) begin : g_bad_chunk
      $error("seq_chunk_adder: WIDTH must be an integer multiple of CHUNK");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;      // effective B operand (inverted for subtract)
   logic [WIDTH-1:0] acc_q;
   logic             carry_q;
   logic [KW-1:0]    k_q;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] sum_q;
   logic             c_out_q;
   logic             ovf_q;

   logic [CHUNK-1:0] a_slice;
   logic [CHUNK-1:0] b_slice;
   logic [CHUNK:0]   slice_sum;
   logic [WIDTH-1:0] acc_d;
   logic [WIDTH-1:0] b_cap;
   logic             carry_cap;

   // Operand conditioning at capture time.
`ifdef SEQ_ADDER_SUB_EN
   assign b_cap     = sub ? ~in2 : in2;
   assign carry_cap = sub ? 1'b1 : c_in;
`else
   assign b_cap     = in2;
   assign carry_cap = c_in;
`endif

   // Slice select and one CHUNK-wide add; the loop is a mux on k_q.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      a_slice = '0;
      b_slice = '0;
      acc_d   = acc_q;
      for (int i = 0; i < NCHUNK; i++) begin
         if (k_q == KW'(i)) begin
            a_slice = a_q[i*CHUNK +: CHUNK];
            b_slice = b_q[i*CHUNK +: CHUNK];
         end
      end
      slice_sum = {1'b0, a_slice} + {1'b0, b_slice} + {{CHUNK{1'b0}}, carry_q};
      for (int i = 0; i < NCHUNK; i++) begin
         if (k_q == KW'(i)) begin
            acc_d[i*CHUNK +: CHUNK] = slice_sum[CHUNK-1:0];
         end
      end
   end

   // NOTE: the operand and accumulator registers are plain flops, not a memory,
   // so they are cleared on reset along with the control state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         carry_q <= 1'b0;
         k_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sum_q   <= '0;
         c_out_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the values
         // from before this edge, independent of statement order.
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  a_q     <= in1;
                  b_q     <= b_cap;
                  carry_q <= carry_cap;
                  acc_q   <= '0;
                  k_q     <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_RUN;
               end
            end
            S_RUN: begin
               acc_q   <= acc_d;
               carry_q <= slice_sum[CHUNK];
               if (k_q == K_LAST) begin
                  // Outputs change only here, so they never show partial sums.
                  sum_q   <= acc_d;
                  c_out_q <= slice_sum[CHUNK];
                  ovf_q   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                             (acc_d[WIDTH-1] != a_q[WIDTH-1]);
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  k_q <= k_q + KW'(1);
               end
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign sum   = sum_q;
   assign c_out = c_out_q;
   assign ovf   = ovf_q;

endmodule

// File: doc/seq_chunk_adder.md
Name: seq_chunk_adder

Overview:
- Multi-cycle parametrised adder: adds two WIDTH-bit operands in CHUNK-bit slices, one slice per clock, LSB slice first.
- Carry is held in a register between slices, so the combinational path is CHUNK bits instead of WIDTH.
- Intended as the area-lean adder datapath for the multi-cycle ALU.
- Start/done handshake; result and flags are held until the next operation completes.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CHUNK, 8, bits added per cycle. WIDTH must be an integer multiple of CHUNK; otherwise elaboration fails.
- NCHUNK (localparam), WIDTH/CHUNK, number of slice cycles.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- in1  in  WIDTH  operand A; captured when start is accepted.
- in2  in  WIDTH  operand B; captured when start is accepted.
- c_in  in  1  carry into bit 0; captured when start is accepted.
- sub  in  1  subtract select; port exists only with SEQ_ADDER_SUB_EN.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse; result valid.
- sum  out  WIDTH  result.
- c_out  out  1  carry out of bit WIDTH-1.
- ovf  out  1  two's-complement signed overflow.

Behaviour:
- Reset: asynchronous, active-high. State goes to IDLE; busy, done, sum, c_out and ovf go to 0; all internal registers are cleared.
- Reset mid-operation aborts the operation: no done pulse, outputs go to 0. The first start after rst deasserts is accepted normally.
- States:
  - IDLE: start=1 at a rising edge latches in1, in2 and c_in into operand/carry registers, sets slice index k=0, goes to RUN.
  - RUN: each cycle computes {carry, acc[k*CHUNK +: CHUNK]} = a_slice + b_slice + carry, then increments k. After the k=NCHUNK-1 slice it goes to DONE.
  - DONE: done=1 for exactly one cycle, then goes to IDLE.
- Output timing:
  - sum, c_out and ovf are registered on the transition into DONE.
  - They hold their values through IDLE and the next RUN; there are no partial or transient values on the outputs.
- Latency: start sampled at edge t → done high in cycle t+NCHUNK+1. busy is high from cycle t+1 through t+NCHUNK+1.
- Throughput: next start can be accepted at the edge ending the first IDLE cycle. This gives one operation per NCHUNK+2 cycles.
- start while busy (RUN or DONE) is ignored; operands are not re-captured. start held high in IDLE begins a new operation immediately.
- ovf = (a[W-1] == b_eff[W-1]) && (sum[W-1] != a[W-1]), where b_eff is the effective B operand.
- Carry wraps modulo 2^WIDTH; the final carry goes to c_out.
- NCHUNK=1 is legal: a single RUN cycle, done at t+2.
- Input changes after capture have no effect on the operation in flight.

Optional Feature:
- Macro SEQ_ADDER_SUB_EN.
- Defined:
  - The sub port exists and is captured with the operands.
  - sub=1 computes in1 + ~in2 + 1: b_eff = ~in2, and the initial carry is forced to 1 with c_in ignored.
  - c_out=1 means no borrow. ovf uses b_eff.
  - sub=0 behaves as plain addition.
- Undefined: no sub port; b_eff = in2 and the initial carry is c_in; addition only.

Test Plan:
- WIDTH=32, CHUNK=8: in1=0x000000FF, in2=0x00000001, c_in=0, start at edge t → done only in cycle t+5; sum=0x00000100, c_out=0, ovf=0 (carry crosses a slice boundary).
- in1=0xFFFFFFFF, in2=0x00000000, c_in=1 → sum=0x00000000, c_out=1, ovf=0; busy high for 5 cycles.
- in1=0x7FFFFFFF, in2=0x00000001, c_in=0 → sum=0x80000000, c_out=0, ovf=1. Then 0x80000000+0x80000000 → sum=0, c_out=1, ovf=1.
- Hold start high with new operands during RUN → ignored; result matches the first operands. Assert rst during RUN → busy=0, done=0 and outputs=0 asynchronously; the next operation 3+4 yields sum=7.
- SEQ_ADDER_SUB_EN, sub=1: in1=5, in2=7 → sum=0xFFFFFFFE, c_out=0, ovf=0. Then in1=7, in2=5 → sum=2, c_out=1.
- CHUNK=32 (NCHUNK=1): 0x12345678+0x11111111 → done at t+2, sum=0x23456789, c_out=0, ovf=0.
